// File: rtl/stopwatch_counter.sv
// Purpose : MM:SS BCD stopwatch with run/pause and 2 Hz adjust mode, fed by divider level outputs.
// Latency : input rise sampled at CLK_REF edge k -> internal pulse in cycle after k+1 -> digits update at edge k+2.
// Backpressure: none; free-running consumer of level inputs, outputs are always valid.
//
// Ports:
//   CLK_REF   - system clock; every flop in this block runs on it
//   RST       - asynchronous active-high reset
//   CLK_1HZ   - 1 Hz level from divider (treated as async data)
//   CLK_2HZ   - 2 Hz level from divider (treated as async data)
//   BTN_PAUSE - debounced pause button, toggles run/pause on each rising edge
//   ADJ       - adjust-mode switch
//   SEL       - adjust field select: 0 = minutes, 1 = seconds
//   MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES - BCD digits
//   RUNNING   - high while counting is enabled
//   ROLLOVER  - one-cycle pulse on MAX_MIN:59 -> 00:00 wrap
module stopwatch_counter #(
  parameter int MAX_MIN = 59
) (
  input  logic       CLK_REF,
  input  logic       RST,
  input  logic       CLK_1HZ,
  input  logic       CLK_2HZ,
  input  logic       BTN_PAUSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       RUNNING,
  output logic       ROLLOVER
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

  // Two-flop synchronizers plus a third "delayed" flop for rising-edge detection.
  logic [2:0] sync_1hz;
  logic [2:0] sync_2hz;
  logic [2:0] sync_btn;
  logic [1:0] sync_adj;

  always_ff @(posedge CLK_REF or posedge RST) begin
    if (RST) begin
      sync_1hz <= '0;
      sync_2hz <= '0;
      sync_btn <= '0;
      sync_adj <= '0;
    end else begin
      sync_1hz <= {sync_1hz[1:0], CLK_1HZ};
      sync_2hz <= {sync_2hz[1:0], CLK_2HZ};
      sync_btn <= {sync_btn[1:0], BTN_PAUSE};
      sync_adj <= {sync_adj[0], ADJ};
    end
  end

  logic tick1;
  logic tick2;
  logic press;
  logic adj_mode;

  assign tick1    = sync_1hz[1] & ~sync_1hz[2];
  assign tick2    = sync_2hz[1] & ~sync_2hz[2];
  assign press    = sync_btn[1] & ~sync_btn[2];
  assign adj_mode = sync_adj[1];

  state_t     state;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       rollover;

  logic min_at_max;
  assign min_at_max = (min_tens == MAX_TENS) && (min_ones == MAX_ONES);

  always_ff @(posedge CLK_REF or posedge RST) begin
    if (RST) begin
      state    <= RUN;
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      rollover <= 1'b0;
    end else begin
      rollover <= 1'b0;
      if (adj_mode) begin
        // State is frozen; tick1/press are dropped. Each field wraps on its own.
        if (tick2) begin
          if (SEL) begin
            if (sec_ones != 4'd9) begin
              sec_ones <= sec_ones + 4'd1;
            end else begin
              sec_ones <= 4'd0;
              sec_tens <= (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
            end
          end else begin
            if (min_at_max) begin
              min_tens <= 4'd0;
              min_ones <= 4'd0;
            end else if (min_ones == 4'd9) begin
              min_ones <= 4'd0;
              min_tens <= min_tens + 4'd1;
            end else begin
              min_ones <= min_ones + 4'd1;
            end
          end
        end
      end else begin
        if (press) begin
          state <= (state == RUN) ? PAUSED : RUN;
        end
        // Count decision uses the pre-toggle state: press+tick in RUN still counts,
        // press+tick in PAUSED resumes without counting.
        if (tick1 && state == RUN) begin
          if (sec_ones != 4'd9) begin
            sec_ones <= sec_ones + 4'd1;
          end else begin
            sec_ones <= 4'd0;
            if (sec_tens != 4'd5) begin
              sec_tens <= sec_tens + 4'd1;
            end else begin
              sec_tens <= 4'd0;
              if (min_at_max) begin
                min_tens <= 4'd0;
                min_ones <= 4'd0;
                rollover <= 1'b1;
              end else if (min_ones == 4'd9) begin
                min_ones <= 4'd0;
                min_tens <= min_tens + 4'd1;
              end else begin
                min_ones <= min_ones + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  assign MIN_TENS = min_tens;
  assign MIN_ONES = min_ones;
  assign SEC_TENS = sec_tens;
  assign SEC_ONES = sec_ones;
  assign RUNNING  = (state == RUN);
  assign ROLLOVER = rollover;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  logic       CLK_REF = 1'b0;
  logic       RST = 1'b1;
  logic       CLK_1HZ = 1'b0;
  logic       CLK_2HZ = 1'b0;
  logic       BTN_PAUSE = 1'b0;
  logic       ADJ = 1'b0;
  logic       SEL = 1'b0;
  logic [3:0] MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
  logic       RUNNING, ROLLOVER;

  stopwatch_counter #(.MAX_MIN(59)) dut (
    .CLK_REF(CLK_REF), .RST(RST), .CLK_1HZ(CLK_1HZ), .CLK_2HZ(CLK_2HZ),
    .BTN_PAUSE(BTN_PAUSE), .ADJ(ADJ), .SEL(SEL),
    .MIN_TENS(MIN_TENS), .MIN_ONES(MIN_ONES), .SEC_TENS(SEC_TENS), .SEC_ONES(SEC_ONES),
    .RUNNING(RUNNING), .ROLLOVER(ROLLOVER)
  );

  always #5 CLK_REF = ~CLK_REF;

  int n_cmp = 0;
  int n_bad = 0;
  int roll_cycles = 0;
  int exp_roll = 0;

  // Count every cycle ROLLOVER is high; a correct one-cycle pulse adds exactly 1.
  always @(negedge CLK_REF) if (ROLLOVER === 1'b1) roll_cycles++;

  // Scoreboard queues: name, {digits, running}, expected rollover cycle count.
  string      q_name[$];
  logic [16:0] q_val[$];
  int         q_roll[$];
  bit         chk_tog = 1'b0;

  // Monitor: whenever stimulus signals a sample point, pop and compare everything queued.
  initial begin
    forever begin
      @(chk_tog);
      while (q_val.size() > 0) begin
        string       nm;
        logic [16:0] ev;
        logic [16:0] av;
        int          er;
        nm = q_name.pop_front();
        ev = q_val.pop_front();
        er = q_roll.pop_front();
        av = {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, RUNNING};
        n_cmp++;
        if (av !== ev || roll_cycles != er) begin
          n_bad++;
          $display("FAIL %s: got %h:%h run=%b roll_cycles=%0d, expected %h:%h run=%b roll_cycles=%0d",
                   nm, av[16:9], av[8:1], av[0], roll_cycles, ev[16:9], ev[8:1], ev[0], er);
        end
      end
    end
  end

  // Watchdog: the whole sequence must finish well within this bound.
  initial begin
    #2ms;
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: wait expired before the test sequence completed");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic expect_now(input string nm, input logic [15:0] dig, input logic run);
    q_name.push_back(nm);
    q_val.push_back({dig, run});
    q_roll.push_back(exp_roll);
    chk_tog = ~chk_tog;
    #0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_REF);
  endtask

  task automatic tick1_n(input int n);
    repeat (n) begin
      CLK_1HZ = 1'b1; cyc(4);
      CLK_1HZ = 1'b0; cyc(4);
    end
  endtask

  task automatic tick2_n(input int n);
    repeat (n) begin
      CLK_2HZ = 1'b1; cyc(4);
      CLK_2HZ = 1'b0; cyc(4);
    end
  endtask

  task automatic press_btn();
    BTN_PAUSE = 1'b1; cyc(4);
    BTN_PAUSE = 1'b0; cyc(4);
  endtask

  task automatic press_and_tick();
    BTN_PAUSE = 1'b1; CLK_1HZ = 1'b1; cyc(4);
    BTN_PAUSE = 1'b0; CLK_1HZ = 1'b0; cyc(4);
  endtask

  task automatic set_adj(input logic v);
    ADJ = v; cyc(4);
  endtask

  task automatic pulse_reset();
    RST = 1'b1; cyc(2);
    RST = 1'b0; cyc(2);
  endtask

  initial begin
    // Reset state
    cyc(3);
    expect_now("reset", 16'h0000, 1'b1);
    n_cmp++;
    if ({MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES} !== 16'h0000 || RUNNING !== 1'b1 || ROLLOVER !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_direct: got %h%h:%h%h run=%b roll=%b, expected 00:00 run=1 roll=0",
               MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, RUNNING, ROLLOVER);
    end
    RST = 1'b0; cyc(2);

    // Basic counting
    tick1_n(3);
    expect_now("count_3", 16'h0003, 1'b1);

    // Preload 00:59, then carry into minutes
    set_adj(1'b1); SEL = 1'b1;
    tick2_n(56);
    expect_now("adj_0059", 16'h0059, 1'b1);
    set_adj(1'b0);
    tick1_n(1);
    expect_now("carry_0100", 16'h0100, 1'b1);

    // Preload 59:59, then rollover
    set_adj(1'b1); SEL = 1'b0;
    tick2_n(58);
    SEL = 1'b1;
    tick2_n(59);
    expect_now("adj_5959", 16'h5959, 1'b1);
    set_adj(1'b0);
    tick1_n(1);
    exp_roll = 1;
    expect_now("rollover", 16'h0000, 1'b1);

    // Pause / resume
    tick1_n(5);
    press_btn();
    expect_now("paused", 16'h0005, 1'b0);
    tick1_n(4);
    expect_now("pause_hold", 16'h0005, 1'b0);
    press_btn();
    tick1_n(1);
    expect_now("resumed", 16'h0006, 1'b1);
    BTN_PAUSE = 1'b1; cyc(100);
    expect_now("btn_held", 16'h0006, 1'b0);
    BTN_PAUSE = 1'b0; cyc(4);
    expect_now("btn_released", 16'h0006, 1'b0);
    press_btn();
    expect_now("run_again", 16'h0006, 1'b1);

    // Adjust mode: field wraps without carry, tick1/press ignored
    pulse_reset();
    set_adj(1'b1); SEL = 1'b0;
    tick2_n(61);
    expect_now("adj_min_wrap", 16'h0100, 1'b1);
    SEL = 1'b1;
    tick2_n(62);
    expect_now("adj_sec_wrap", 16'h0102, 1'b1);
    tick1_n(1);
    press_btn();
    expect_now("adj_ignores", 16'h0102, 1'b1);
    set_adj(1'b0);
    tick1_n(1);
    expect_now("post_adj", 16'h0103, 1'b1);

    // Simultaneous press and tick1
    pulse_reset();
    tick1_n(10);
    expect_now("at_0010", 16'h0010, 1'b1);
    press_and_tick();
    expect_now("same_run", 16'h0011, 1'b0);
    press_and_tick();
    expect_now("same_paused", 16'h0011, 1'b1);

    // 12:34 then asynchronous reset mid-cycle
    set_adj(1'b1); SEL = 1'b0;
    tick2_n(12);
    SEL = 1'b1;
    tick2_n(23);
    set_adj(1'b0);
    expect_now("at_1234", 16'h1234, 1'b1);
    @(posedge CLK_REF); #2;
    RST = 1'b1;
    #1;
    expect_now("async_reset", 16'h0000, 1'b1);
    cyc(1);
    RST = 1'b0;
    cyc(3);

    // Latency: rise first sampled at edge k -> visible after edge k+2
    CLK_1HZ = 1'b1;
    @(posedge CLK_REF);        // edge k
    @(posedge CLK_REF); #1;    // after edge k+1
    expect_now("lat_k1", 16'h0000, 1'b1);
    @(posedge CLK_REF); #1;    // after edge k+2
    expect_now("lat_k2", 16'h0001, 1'b1);
    cyc(2);
    CLK_1HZ = 1'b0; cyc(4);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
